// File: rtl/ether_pkg.sv
// ============================================================================
// ether_pkg : shared types and constants for the RMII receive controller
// Rev 1.0
// ============================================================================
`default_nettype none

package ether_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } state_e;

    localparam logic [1:0] PREAMBLE_DIBIT    = 2'b01;
    localparam logic [1:0] SFD_DIBIT         = 2'b11;
    localparam int         DEFAULT_MAX_BYTES = 1518;
    localparam int         BYTE_COUNT_W      = 11;

endpackage

`default_nettype wire

// File: rtl/ether_rx_ctrl.sv
// ============================================================================
// ether_rx_ctrl : RMII preamble/SFD detector and payload dibit forwarder
// Rev 1.0
// ============================================================================
`default_nettype none

module ether_rx_ctrl
    import ether_pkg::*;
#(
    parameter int PREAMBLE_MIN = 8,
    parameter int MAX_BYTES    = DEFAULT_MAX_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    crsdv,
    input  logic [1:0]              rxd,
    output logic                    axiov,
    output logic [1:0]              axiod,
    output logic [BYTE_COUNT_W-1:0] byte_count,
    output logic                    frame_done,
    output logic                    frame_err
);

    localparam int                      PCNT_W   = $clog2(PREAMBLE_MIN + 2);
    localparam logic [PCNT_W-1:0]       PCNT_MIN = PCNT_W'(PREAMBLE_MIN);
    localparam logic [BYTE_COUNT_W-1:0] BCNT_MAX = BYTE_COUNT_W'(MAX_BYTES);

    state_e                  state_q, state_d;
    logic [PCNT_W-1:0]       pcnt_q, pcnt_d;
    logic [1:0]              dcnt_q, dcnt_d;
    logic [BYTE_COUNT_W-1:0] bcnt_q, bcnt_d;
    logic                    axiov_q, axiov_d;
    logic [1:0]              axiod_q, axiod_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        dcnt_d  = dcnt_q;
        bcnt_d  = bcnt_q;
        axiov_d = 1'b0;
        axiod_d = 2'b00;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (crsdv && rxd == PREAMBLE_DIBIT) begin
                    state_d = ST_PREAMBLE;
                    pcnt_d  = PCNT_W'(1);
                end
            end
            ST_PREAMBLE: begin
                if (!crsdv) begin
                    state_d = ST_IDLE;
                    pcnt_d  = '0;
                end else if (rxd == PREAMBLE_DIBIT) begin
                    if (pcnt_q < PCNT_MIN) begin
                        pcnt_d = pcnt_q + PCNT_W'(1);
                    end
                end else if (rxd == SFD_DIBIT && pcnt_q >= PCNT_MIN) begin
                    state_d = ST_DATA;
                    pcnt_d  = '0;
                    dcnt_d  = 2'd0;
                    bcnt_d  = '0;
                end else begin
                    state_d = ST_DROP;
                    pcnt_d  = '0;
                end
            end
            ST_DATA: begin
                if (!crsdv) begin
                    // Carrier loss ends the frame; partial byte or empty payload is malformed.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = (dcnt_q != 2'd0) || (bcnt_q == '0);
                end else if (bcnt_q == BCNT_MAX && dcnt_q == 2'd0) begin
                    state_d = ST_DROP;
                    err_d   = 1'b1;
                end else begin
                    axiov_d = 1'b1;
                    axiod_d = rxd;
                    dcnt_d  = dcnt_q + 2'd1;
                    if (dcnt_q == 2'd3) begin
                        bcnt_d = bcnt_q + BYTE_COUNT_W'(1);
                    end
                end
            end
            ST_DROP: begin
                if (!crsdv) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_DROP;
            end
        endcase
    end

    // Reset lands in DROP so a frame already in flight at release is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DROP;
            pcnt_q  <= '0;
            dcnt_q  <= 2'd0;
            bcnt_q  <= '0;
            axiov_q <= 1'b0;
            axiod_q <= 2'b00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            dcnt_q  <= dcnt_d;
            bcnt_q  <= bcnt_d;
            axiov_q <= axiov_d;
            axiod_q <= axiod_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign axiov      = axiov_q;
    assign axiod      = axiod_q;
    assign byte_count = bcnt_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ether_rx_ctrl.sv
// ============================================================================
// tb_ether_rx_ctrl : directed + random stimulus against a burst-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ether_rx_ctrl;
    import ether_pkg::*;

    localparam int NMAX    = 8192;
    localparam int PRE_MIN = 8;
    localparam int NSC     = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        crsdv = 1'b0;
    logic [1:0]  rxd = 2'b00;

    logic        v_a, v_b, dn_a, dn_b, er_a, er_b;
    logic [1:0]  d_a, d_b;
    logic [10:0] bc_a, bc_b;

    ether_rx_ctrl #(.PREAMBLE_MIN(PRE_MIN), .MAX_BYTES(DEFAULT_MAX_BYTES)) dut_a (
        .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
        .axiov(v_a), .axiod(d_a), .byte_count(bc_a),
        .frame_done(dn_a), .frame_err(er_a)
    );

    ether_rx_ctrl #(.PREAMBLE_MIN(PRE_MIN), .MAX_BYTES(4)) dut_b (
        .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
        .axiov(v_b), .axiod(d_b), .byte_count(bc_b),
        .frame_done(dn_b), .frame_err(er_b)
    );

    always #5 clk = ~clk;

    // stimulus per cycle
    logic       cv[NMAX];
    logic [1:0] dv[NMAX];
    logic       rv[NMAX];
    int         ns = 0;
    int         sc[NSC];

    // expected outputs per cycle, [0]=default DUT, [1]=MAX_BYTES=4 DUT
    logic       ev [2][NMAX+1];
    logic [1:0] ed [2][NMAX+1];
    logic       edn[2][NMAX+1];
    logic       eer[2][NMAX+1];
    int         ebc[2][NMAX+1];

    int total = 0;
    int bad   = 0;
    int va[NSC], da[NSC], ea[NSC], ba[NSC];
    int vb[NSC], db[NSC], eb[NSC], bb[NSC];

    task automatic chk(input string nm, input int cyc, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic put(input logic c, input logic [1:0] d, input logic r);
        if (ns < NMAX) begin
            cv[ns] = c;
            dv[ns] = d;
            rv[ns] = r;
            ns++;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) put(1'b0, 2'($urandom), 1'b0);
    endtask

    task automatic pre(input int k);
        repeat (k) put(1'b1, PREAMBLE_DIBIT, 1'b0);
    endtask

    task automatic dat(input int k);
        repeat (k) put(1'b1, 2'($urandom), 1'b0);
    endtask

    // A carrier burst (run of crsdv=1 outside reset) is only parsed if the cycle
    // before it was a quiet, non-reset cycle; every such cycle leaves the receiver idle.
    task automatic build_model(input int m, input int mx);
        int bce[NMAX+1];
        int s, e, p, q, n, f, cur;
        for (int c = 0; c <= NMAX; c++) begin
            ev[m][c] = 1'b0; ed[m][c] = 2'b00; edn[m][c] = 1'b0; eer[m][c] = 1'b0;
            bce[c] = -1;
        end
        s = 0;
        while (s < ns) begin
            if (!(cv[s] && !rv[s])) begin
                s++;
            end else begin
                e = s;
                while (e < ns && cv[e] && !rv[e]) e++;
                if (s > 0 && !cv[s-1] && !rv[s-1]) begin
                    p = s;
                    while (p < e && dv[p] != 2'b01) p++;
                    q = p;
                    while (q < e && dv[q] == 2'b01) q++;
                    if (p < e && q < e && dv[q] == 2'b11 && (q - p) >= PRE_MIN) begin
                        n = e - q - 1;
                        f = (n < 4 * mx) ? n : 4 * mx;
                        bce[q+1] = 0;
                        for (int i = 0; i < f; i++) begin
                            ev[m][q+2+i]  = 1'b1;
                            ed[m][q+2+i]  = dv[q+1+i];
                            bce[q+2+i]    = (i + 1) / 4;
                        end
                        if (n > 4 * mx) begin
                            eer[m][q+2+4*mx] = 1'b1;
                        end else if (e < ns && !rv[e]) begin
                            edn[m][e+1] = 1'b1;
                            if ((n % 4) != 0 || n < 4) eer[m][e+1] = 1'b1;
                        end
                    end
                end
                s = e;
            end
        end
        cur = 0;
        for (int c = 0; c <= ns; c++) begin
            if (c > 0 && rv[c-1]) cur = 0;
            else if (bce[c] >= 0) cur = bce[c];
            ebc[m][c] = cur;
        end
    endtask

    function automatic int sid_of(input int k);
        int r = 0;
        for (int j = 0; j < NSC; j++) if (k >= sc[j]) r = j;
        return r;
    endfunction

    initial begin
        logic [1:0] jd;
        int n, rpos;

        // 0: reset, quiet line
        sc[0] = ns;
        put(1'b0, 2'b00, 1'b1); put(1'b0, 2'b00, 1'b1); put(1'b0, 2'b00, 1'b1);
        idle(2);
        // 1: long preamble, 2 bytes of 0x55
        sc[1] = ns;
        pre(31); put(1'b1, SFD_DIBIT, 1'b0); pre(8); idle(3);
        // 2: short preamble is rejected
        sc[2] = ns;
        pre(4); put(1'b1, SFD_DIBIT, 1'b0); dat(8); idle(3);
        // 3: partial trailing byte
        sc[3] = ns;
        pre(8); put(1'b1, SFD_DIBIT, 1'b0); dat(6); idle(3);
        // 4: 5-byte frame (oversize for MAX_BYTES=4)
        sc[4] = ns;
        pre(8); put(1'b1, SFD_DIBIT, 1'b0); dat(20); idle(3);
        // 5: back-to-back frames with one idle cycle between
        sc[5] = ns;
        pre(8); put(1'b1, SFD_DIBIT, 1'b0); dat(8); idle(1);
        pre(8); put(1'b1, SFD_DIBIT, 1'b0); dat(12); idle(3);
        // 6: reset in the middle of a frame, carrier stays up
        sc[6] = ns;
        pre(8); put(1'b1, SFD_DIBIT, 1'b0); dat(4);
        put(1'b1, 2'($urandom), 1'b1); put(1'b1, 2'($urandom), 1'b1);
        pre(8); put(1'b1, SFD_DIBIT, 1'b0); dat(3); idle(3);
        // 7: fresh frame after recovery
        sc[7] = ns;
        pre(8); put(1'b1, SFD_DIBIT, 1'b0); dat(8); idle(3);
        // 8: random frames
        sc[8] = ns;
        for (int f = 0; f < 80; f++) begin
            idle($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    jd = 2'($urandom_range(0, 2));
                    put(1'b1, (jd == 2'd0) ? 2'b00 : (jd == 2'd1) ? 2'b10 : 2'b11, 1'b0);
                end
            end
            pre($urandom_range(4, 12));
            put(1'b1, ($urandom_range(0, 7) == 0) ? 2'b10 : SFD_DIBIT, 1'b0);
            n    = $urandom_range(0, 24);
            rpos = ($urandom_range(0, 15) == 0) ? $urandom_range(0, n) : -1;
            for (int i = 0; i < n; i++) begin
                if (i == rpos) begin
                    put(1'b1, 2'($urandom), 1'b1);
                    put(1'b1, 2'($urandom), 1'b1);
                end
                put(1'b1, 2'($urandom), 1'b0);
            end
        end
        idle(5);

        build_model(0, DEFAULT_MAX_BYTES);
        build_model(1, 4);

        for (int j = 0; j < NSC; j++) begin
            va[j] = 0; da[j] = 0; ea[j] = 0; ba[j] = 0;
            vb[j] = 0; db[j] = 0; eb[j] = 0; bb[j] = 0;
        end

        #1;
        for (int k = 0; k <= ns; k++) begin
            int sid;
            sid = sid_of(k);
            chk("A.axiov",      k, int'(v_a),  int'(ev[0][k]));
            chk("A.axiod",      k, int'(d_a),  int'(ed[0][k]));
            chk("A.byte_count", k, int'(bc_a), ebc[0][k]);
            chk("A.frame_done", k, int'(dn_a), int'(edn[0][k]));
            chk("A.frame_err",  k, int'(er_a), int'(eer[0][k]));
            chk("B.axiov",      k, int'(v_b),  int'(ev[1][k]));
            chk("B.axiod",      k, int'(d_b),  int'(ed[1][k]));
            chk("B.byte_count", k, int'(bc_b), ebc[1][k]);
            chk("B.frame_done", k, int'(dn_b), int'(edn[1][k]));
            chk("B.frame_err",  k, int'(er_b), int'(eer[1][k]));
            va[sid] += int'(v_a); da[sid] += int'(dn_a); ea[sid] += int'(er_a); ba[sid] = int'(bc_a);
            vb[sid] += int'(v_b); db[sid] += int'(dn_b); eb[sid] += int'(er_b); bb[sid] = int'(bc_b);
            if (k < ns) begin
                crsdv = cv[k];
                rxd   = dv[k];
                rst   = rv[k];
                if (rv[k] && (k == 0 || !rv[k-1])) begin
                    #1;
                    chk("A.rst_now_out", k, int'({v_a, d_a, dn_a, er_a}), 0);
                    chk("A.rst_now_bc",  k, int'(bc_a), 0);
                    chk("B.rst_now_out", k, int'({v_b, d_b, dn_b, er_b}), 0);
                    chk("B.rst_now_bc",  k, int'(bc_b), 0);
                end
                @(posedge clk);
                #1;
            end
        end

        chk("sc1.A.axiov_cycles", 1, va[1], 8);
        chk("sc1.A.done_pulses",  1, da[1], 1);
        chk("sc1.A.err_pulses",   1, ea[1], 0);
        chk("sc1.A.byte_count",   1, ba[1], 2);
        chk("sc1.B.axiov_cycles", 1, vb[1], 8);
        chk("sc2.A.axiov_cycles", 2, va[2], 0);
        chk("sc2.A.pulses",       2, da[2] + ea[2], 0);
        chk("sc2.A.byte_count",   2, ba[2], 2);
        chk("sc3.A.axiov_cycles", 3, va[3], 6);
        chk("sc3.A.done_pulses",  3, da[3], 1);
        chk("sc3.A.err_pulses",   3, ea[3], 1);
        chk("sc3.A.byte_count",   3, ba[3], 1);
        chk("sc4.A.axiov_cycles", 4, va[4], 20);
        chk("sc4.A.done_pulses",  4, da[4], 1);
        chk("sc4.A.byte_count",   4, ba[4], 5);
        chk("sc4.B.axiov_cycles", 4, vb[4], 16);
        chk("sc4.B.done_pulses",  4, db[4], 0);
        chk("sc4.B.err_pulses",   4, eb[4], 1);
        chk("sc4.B.byte_count",   4, bb[4], 4);
        chk("sc5.A.axiov_cycles", 5, va[5], 20);
        chk("sc5.A.done_pulses",  5, da[5], 2);
        chk("sc5.A.err_pulses",   5, ea[5], 0);
        chk("sc5.A.byte_count",   5, ba[5], 3);
        chk("sc6.A.axiov_cycles", 6, va[6], 4);
        chk("sc6.A.pulses",       6, da[6] + ea[6], 0);
        chk("sc6.A.byte_count",   6, ba[6], 0);
        chk("sc7.A.axiov_cycles", 7, va[7], 8);
        chk("sc7.A.done_pulses",  7, da[7], 1);
        chk("sc7.A.byte_count",   7, ba[7], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
